pipelined_control_unit: RTL and testbench



---
 rtl/lc_ctrl_pkg.sv | 74 +++++++
 rtl/pipelined_control_unit_decode.sv | 80 ++++++++
 rtl/pipelined_control_unit.sv | 140 ++++++++++++++
 tb/tb_pipelined_control_unit.sv | 354 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/lc_ctrl_pkg.sv
// Shared definitions for the pipelined LEGv8 control unit: opcodes, ALUOp codes, cond codes, control bundle.
// Latency: n/a (constants, types and pure functions only).
// Backpressure: n/a.
package lc_ctrl_pkg;

    localparam int ALUOP_BITS = 3;

    // ALUOp encodings
    localparam logic [ALUOP_BITS-1:0] ALUOP_PASSB = 3'b000;
    localparam logic [ALUOP_BITS-1:0] ALUOP_ADD   = 3'b010;
    localparam logic [ALUOP_BITS-1:0] ALUOP_SUB   = 3'b011;
    localparam logic [ALUOP_BITS-1:0] ALUOP_AND   = 3'b100;
    localparam logic [ALUOP_BITS-1:0] ALUOP_XOR   = 3'b110;

    // Full 11-bit opcodes (instruction[31:21])
    localparam logic [10:0] OP_LDUR = 11'b11111000010;
    localparam logic [10:0] OP_STUR = 11'b11111000000;
    localparam logic [10:0] OP_ADDS = 11'b10101011000;
    localparam logic [10:0] OP_SUBS = 11'b11101011000;
    localparam logic [10:0] OP_AND  = 11'b10001010000;
    localparam logic [10:0] OP_EOR  = 11'b11001010000;
    localparam logic [10:0] OP_LSR  = 11'b11010011010;
    // Shorter opcodes, compared against the top bits only
    localparam logic [9:0]  OP_ADDI  = 10'b1001000100;
    localparam logic [5:0]  OP_B     = 6'b000101;
    localparam logic [7:0]  OP_CBZ   = 8'b10110100;
    localparam logic [7:0]  OP_BCOND = 8'b01010100;

    // B.cond condition codes (instruction[3:0])
    localparam logic [3:0] COND_EQ = 4'h0;
    localparam logic [3:0] COND_NE = 4'h1;
    localparam logic [3:0] COND_GE = 4'hA;
    localparam logic [3:0] COND_LT = 4'hB;

    typedef struct packed {
        logic                  ALUSrc;
        logic                  ShiftEn;
        logic                  SetFlags;
        logic [ALUOP_BITS-1:0] ALUOp;
        logic                  MemWrite;
        logic                  MemRead;
        logic                  RegWrite;
        logic                  MemToReg;
    } ctrl_t;

    // nzvc = {N,Z,V,C}; C is not consulted by any supported condition.
    function automatic logic cond_eval(input logic [3:0] cond, input logic [3:0] nzvc);
        logic res;
        logic unused_c;
        unused_c = nzvc[0];
        case (cond)
            COND_EQ: res = nzvc[2];
            COND_NE: res = ~nzvc[2];
            COND_LT: res = nzvc[3] ^ nzvc[1];
            COND_GE: res = ~(nzvc[3] ^ nzvc[1]);
            default: res = 1'b0;
        endcase
        return res;
    endfunction

    // Mask bit order: bit0 EQ, bit1 NE, bit2 LT, bit3 GE.
    function automatic logic cond_enabled(input logic [3:0] cond, input logic [3:0] en);
        logic res;
        case (cond)
            COND_EQ: res = en[0];
            COND_NE: res = en[1];
            COND_LT: res = en[2];
            COND_GE: res = en[3];
            default: res = 1'b0;
        endcase
        return res;
    endfunction

endpackage

// File: rtl/pipelined_control_unit_decode.sv
// Combinational ID-stage decoder: opcode + cond -> control bundle, branch class, Reg2Loc, illegal.
// Latency: 0 cycles (pure combinational).
// Backpressure: none; qualification by valid/flush happens in the parent.
module ctrl_decode
    import lc_ctrl_pkg::*;
#(
    parameter logic [3:0] COND_EN = 4'b0111
) (
    input  logic [10:0] i_opcode,     // instruction[31:21]
    input  logic [3:0]  i_cond,       // instruction[3:0]
    output ctrl_t       o_ctrl,       // EX/MEM/WB control bundle
    output logic        o_reg2loc,
    output logic        o_uncond_br,
    output logic        o_is_b,
    output logic        o_is_cbz,
    output logic        o_is_bcond,   // only for enabled condition codes
    output logic        o_illegal
);

    always_comb begin
        o_ctrl      = '0;
        o_reg2loc   = 1'b0;
        o_uncond_br = 1'b0;
        o_is_b      = 1'b0;
        o_is_cbz    = 1'b0;
        o_is_bcond  = 1'b0;
        o_illegal   = 1'b0;
        if (i_opcode == OP_LDUR) begin
            o_ctrl.ALUSrc   = 1'b1;
            o_ctrl.ALUOp    = ALUOP_ADD;
            o_ctrl.MemRead  = 1'b1;
            o_ctrl.RegWrite = 1'b1;
            o_ctrl.MemToReg = 1'b1;
        end else if (i_opcode == OP_STUR) begin
            // Store data register sits in the Rt field, hence Reg2Loc.
            o_reg2loc       = 1'b1;
            o_ctrl.ALUSrc   = 1'b1;
            o_ctrl.ALUOp    = ALUOP_ADD;
            o_ctrl.MemWrite = 1'b1;
        end else if (i_opcode[10:1] == OP_ADDI) begin
            o_ctrl.ALUSrc   = 1'b1;
            o_ctrl.ALUOp    = ALUOP_ADD;
            o_ctrl.RegWrite = 1'b1;
        end else if (i_opcode == OP_ADDS) begin
            o_ctrl.ALUOp    = ALUOP_ADD;
            o_ctrl.SetFlags = 1'b1;
            o_ctrl.RegWrite = 1'b1;
        end else if (i_opcode == OP_SUBS) begin
            o_ctrl.ALUOp    = ALUOP_SUB;
            o_ctrl.SetFlags = 1'b1;
            o_ctrl.RegWrite = 1'b1;
        end else if (i_opcode == OP_AND) begin
            o_ctrl.ALUOp    = ALUOP_AND;
            o_ctrl.RegWrite = 1'b1;
        end else if (i_opcode == OP_EOR) begin
            o_ctrl.ALUOp    = ALUOP_XOR;
            o_ctrl.RegWrite = 1'b1;
        end else if (i_opcode == OP_LSR) begin
            // Shifter does the work; the ALU just passes its B operand through.
            o_ctrl.ShiftEn  = 1'b1;
            o_ctrl.ALUOp    = ALUOP_PASSB;
            o_ctrl.RegWrite = 1'b1;
        end else if (i_opcode[10:5] == OP_B) begin
            o_uncond_br = 1'b1;
            o_is_b      = 1'b1;
        end else if (i_opcode[10:3] == OP_CBZ) begin
            o_reg2loc = 1'b1;
            o_is_cbz  = 1'b1;
        end else if (i_opcode[10:3] == OP_BCOND) begin
            if (cond_enabled(i_cond, COND_EN)) begin
                o_is_bcond = 1'b1;
            end else begin
                o_illegal = 1'b1;
            end
        end else begin
            o_illegal = 1'b1;
        end
    end

endmodule

// File: rtl/pipelined_control_unit.sv
// Pipelined LEGv8 control: decodes ID, carries controls through EX/MEM/WB, owns NZVC, resolves branches in ID.
// Latency: ALU controls +1, memory controls +2, writeback controls +3 cycles after ID.
// Backpressure: stall holds ID (EX gets a bubble, MEM/WB keep draining); flush squashes ID; flag_hazard asks for a stall.
// Ports: clk/reset (async, active-high); instruction/instr_valid/stall/flush/rd_zero and live alu_* flags in;
//        ID-stage Reg2Loc/UncondBr/BrTaken/flag_hazard/illegal, ex_*/mem_*/wb_* registered controls and flags out.
module pipelined_control_unit
    import lc_ctrl_pkg::*;
#(
    parameter int         ALUOP_W  = 3,
    parameter int         FLAG_FWD = 1,
    parameter logic [3:0] COND_EN  = 4'b0111
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [31:0]        instruction,
    input  logic               instr_valid,
    input  logic               stall,
    input  logic               flush,
    input  logic               rd_zero,
    input  logic               alu_negative,
    input  logic               alu_zero,
    input  logic               alu_overflow,
    input  logic               alu_carry,
    output logic               Reg2Loc,
    output logic               UncondBr,
    output logic               BrTaken,
    output logic               flag_hazard,
    output logic               illegal,
    output logic               ex_ALUSrc,
    output logic               ex_ShiftEn,
    output logic               ex_SetFlags,
    output logic [ALUOP_W-1:0] ex_ALUOp,
    output logic               mem_MemWrite,
    output logic               mem_MemRead,
    output logic               wb_RegWrite,
    output logic               wb_MemToReg,
    output logic [3:0]         flags
);

    localparam bit P_FWD = (FLAG_FWD != 0);

    ctrl_t      w_dec_ctrl;
    logic       w_dec_reg2loc;
    logic       w_dec_uncond;
    logic       w_dec_is_b;
    logic       w_dec_is_cbz;
    logic       w_dec_is_bcond;
    logic       w_dec_illegal;

    logic       w_id_ok;
    logic       w_id_load;
    logic       w_ex_setter;
    logic [3:0] w_alu_flags;
    logic [3:0] w_fsel;
    logic       w_hazard;
    logic       w_unused_bits;

    ctrl_t      r_ex_ctrl;
    logic       r_ex_valid;
    logic       r_mem_mem_write;
    logic       r_mem_mem_read;
    logic       r_mem_reg_write;
    logic       r_mem_mem_to_reg;
    logic       r_wb_reg_write;
    logic       r_wb_mem_to_reg;
    logic [3:0] r_flags;

    ctrl_decode #(
        .COND_EN (COND_EN)
    ) u_decode (
        .i_opcode    (instruction[31:21]),
        .i_cond      (instruction[3:0]),
        .o_ctrl      (w_dec_ctrl),
        .o_reg2loc   (w_dec_reg2loc),
        .o_uncond_br (w_dec_uncond),
        .o_is_b      (w_dec_is_b),
        .o_is_cbz    (w_dec_is_cbz),
        .o_is_bcond  (w_dec_is_bcond),
        .o_illegal   (w_dec_illegal)
    );

    // Register/immediate fields are consumed by the datapath, not here.
    assign w_unused_bits = ^instruction[20:4];

    assign w_id_ok     = instr_valid & ~flush;
    assign w_id_load   = instr_valid & ~stall & ~flush;
    assign w_ex_setter = r_ex_valid & r_ex_ctrl.SetFlags;
    assign w_alu_flags = {alu_negative, alu_zero, alu_overflow, alu_carry};

    // Flags a B.cond in ID should see: the EX result if it is about to land in NZVC and forwarding is built.
    assign w_fsel   = (P_FWD && w_ex_setter) ? w_alu_flags : r_flags;
    // Without forwarding the register is one cycle stale while a setter sits in EX.
    assign w_hazard = ~P_FWD & w_id_ok & w_dec_is_bcond & w_ex_setter;

    assign Reg2Loc     = w_id_ok & w_dec_reg2loc;
    assign UncondBr    = w_id_ok & w_dec_uncond;
    assign flag_hazard = w_hazard;
    assign illegal     = w_id_ok & w_dec_illegal;
    assign BrTaken     = w_id_ok & ( w_dec_is_b
                                   | (w_dec_is_cbz & rd_zero)
                                   | (w_dec_is_bcond & ~w_hazard & cond_eval(instruction[3:0], w_fsel)));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_ex_valid       <= 1'b0;
            r_ex_ctrl        <= '0;
            r_mem_mem_write  <= 1'b0;
            r_mem_mem_read   <= 1'b0;
            r_mem_reg_write  <= 1'b0;
            r_mem_mem_to_reg <= 1'b0;
            r_wb_reg_write   <= 1'b0;
            r_wb_mem_to_reg  <= 1'b0;
            r_flags          <= 4'b0000;
        end else begin
            // Bubbles carry an all-zero bundle so downstream stages need no valid qualification.
            r_ex_valid       <= w_id_load;
            r_ex_ctrl        <= w_id_load ? w_dec_ctrl : '0;
            r_mem_mem_write  <= r_ex_ctrl.MemWrite;
            r_mem_mem_read   <= r_ex_ctrl.MemRead;
            r_mem_reg_write  <= r_ex_ctrl.RegWrite;
            r_mem_mem_to_reg <= r_ex_ctrl.MemToReg;
            r_wb_reg_write   <= r_mem_reg_write;
            r_wb_mem_to_reg  <= r_mem_mem_to_reg;
            if (w_ex_setter) begin
                r_flags <= w_alu_flags;
            end
        end
    end

    assign ex_ALUSrc    = r_ex_ctrl.ALUSrc;
    assign ex_ShiftEn   = r_ex_ctrl.ShiftEn;
    assign ex_SetFlags  = r_ex_ctrl.SetFlags;
    assign ex_ALUOp     = ALUOP_W'(r_ex_ctrl.ALUOp);
    assign mem_MemWrite = r_mem_mem_write;
    assign mem_MemRead  = r_mem_mem_read;
    assign wb_RegWrite  = r_wb_reg_write;
    assign wb_MemToReg  = r_wb_mem_to_reg;
    assign flags        = r_flags;

endmodule

// File: tb/tb_pipelined_control_unit.sv
// Self-checking bench: two DUTs (flag forwarding on / off) share stimulus; table vectors, directed corner sequences, random vs model.
// Latency: n/a.
// Backpressure: n/a.
module tb_pipelined_control_unit;

    typedef enum int {K_LDUR, K_STUR, K_ADDI, K_ADDS, K_SUBS, K_AND, K_EOR, K_LSR,
                      K_B, K_CBZ, K_BC, K_JUNK} kind_e;

    // {alusrc, shiften, setflags, aluop[2:0], memwrite, memread, regwrite, memtoreg}
    typedef struct packed {
        logic       alusrc;
        logic       shiften;
        logic       setflags;
        logic [2:0] aluop;
        logic       memwrite;
        logic       memread;
        logic       regwrite;
        logic       memtoreg;
    } bctl_t;

    typedef struct {
        kind_e      k;
        logic [3:0] cond;
        logic       vld;
        logic       fl;
        logic       rz;
        logic [3:0] exp_id;   // {Reg2Loc, UncondBr, BrTaken, illegal}
        logic [9:0] exp_ctl;  // bundle expected in EX one cycle later
    } vec_t;

    localparam logic [3:0] TB_COND_EN = 4'b0111;
    localparam int NV = 24;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] instruction;
    logic        instr_valid, stall, flush, rd_zero;
    logic        alu_n, alu_z, alu_v, alu_c;

    logic        o1_r2l, o1_ub, o1_br, o1_fh, o1_ill, o1_alusrc, o1_shen, o1_setf;
    logic [2:0]  o1_aluop;
    logic        o1_mw, o1_mr, o1_rw, o1_m2r;
    logic [3:0]  o1_flags;
    logic        o0_r2l, o0_ub, o0_br, o0_fh, o0_ill, o0_alusrc, o0_shen, o0_setf;
    logic [2:0]  o0_aluop;
    logic        o0_mw, o0_mr, o0_rw, o0_m2r;
    logic [3:0]  o0_flags;
    logic [18:0] w1_pack, w0_pack;

    int checks   = 0;
    int failures = 0;

    vec_t        tbl [NV];
    bctl_t       m_ex [2];
    bctl_t       m_mem [2];
    bctl_t       m_wb [2];
    logic        m_exv [2];
    logic [3:0]  m_flags [2];
    logic [3:0]  conds [5];

    always #5 clk = ~clk;

    pipelined_control_unit #(.ALUOP_W(3), .FLAG_FWD(1), .COND_EN(TB_COND_EN)) u_dut_fwd (
        .clk(clk), .reset(reset), .instruction(instruction), .instr_valid(instr_valid),
        .stall(stall), .flush(flush), .rd_zero(rd_zero),
        .alu_negative(alu_n), .alu_zero(alu_z), .alu_overflow(alu_v), .alu_carry(alu_c),
        .Reg2Loc(o1_r2l), .UncondBr(o1_ub), .BrTaken(o1_br), .flag_hazard(o1_fh), .illegal(o1_ill),
        .ex_ALUSrc(o1_alusrc), .ex_ShiftEn(o1_shen), .ex_SetFlags(o1_setf), .ex_ALUOp(o1_aluop),
        .mem_MemWrite(o1_mw), .mem_MemRead(o1_mr), .wb_RegWrite(o1_rw), .wb_MemToReg(o1_m2r),
        .flags(o1_flags));

    pipelined_control_unit #(.ALUOP_W(3), .FLAG_FWD(0), .COND_EN(TB_COND_EN)) u_dut_stall (
        .clk(clk), .reset(reset), .instruction(instruction), .instr_valid(instr_valid),
        .stall(stall), .flush(flush), .rd_zero(rd_zero),
        .alu_negative(alu_n), .alu_zero(alu_z), .alu_overflow(alu_v), .alu_carry(alu_c),
        .Reg2Loc(o0_r2l), .UncondBr(o0_ub), .BrTaken(o0_br), .flag_hazard(o0_fh), .illegal(o0_ill),
        .ex_ALUSrc(o0_alusrc), .ex_ShiftEn(o0_shen), .ex_SetFlags(o0_setf), .ex_ALUOp(o0_aluop),
        .mem_MemWrite(o0_mw), .mem_MemRead(o0_mr), .wb_RegWrite(o0_rw), .wb_MemToReg(o0_m2r),
        .flags(o0_flags));

    assign w1_pack = {o1_r2l, o1_ub, o1_br, o1_fh, o1_ill, o1_alusrc, o1_shen, o1_setf, o1_aluop,
                      o1_mw, o1_mr, o1_rw, o1_m2r, o1_flags};
    assign w0_pack = {o0_r2l, o0_ub, o0_br, o0_fh, o0_ill, o0_alusrc, o0_shen, o0_setf, o0_aluop,
                      o0_mw, o0_mr, o0_rw, o0_m2r, o0_flags};

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%h expected 0x%h", name, act, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [31:0] ins, input logic v, input logic st, input logic fl,
                         input logic rz, input logic [3:0] nzvc);
        instruction = ins;
        instr_valid = v;
        stall       = st;
        flush       = fl;
        rd_zero     = rz;
        {alu_n, alu_z, alu_v, alu_c} = nzvc;
    endtask

    function automatic logic [31:0] mk_instr(input kind_e k, input logic [3:0] c);
        logic [31:0] r;
        r = $urandom;
        case (k)
            K_LDUR:  return {11'b11111000010, r[20:0]};
            K_STUR:  return {11'b11111000000, r[20:0]};
            K_ADDI:  return {10'b1001000100, r[21:0]};
            K_ADDS:  return {11'b10101011000, r[20:0]};
            K_SUBS:  return {11'b11101011000, r[20:0]};
            K_AND:   return {11'b10001010000, r[20:0]};
            K_EOR:   return {11'b11001010000, r[20:0]};
            K_LSR:   return {11'b11010011010, r[20:0]};
            K_B:     return {6'b000101, r[25:0]};
            K_CBZ:   return {8'b10110100, r[23:0]};
            K_BC:    return {8'b01010100, r[23:4], c};
            default: return r[0] ? 32'hFFFF_FFFF : 32'h0000_0000;
        endcase
    endfunction

    // Reference: what each instruction class needs from the datapath.
    function automatic bctl_t kind_ctl(input kind_e k);
        bctl_t c;
        c = '0;
        case (k)
            K_LDUR: begin c.alusrc = 1; c.aluop = 3'b010; c.memread = 1; c.regwrite = 1; c.memtoreg = 1; end
            K_STUR: begin c.alusrc = 1; c.aluop = 3'b010; c.memwrite = 1; end
            K_ADDI: begin c.alusrc = 1; c.aluop = 3'b010; c.regwrite = 1; end
            K_ADDS: begin c.setflags = 1; c.aluop = 3'b010; c.regwrite = 1; end
            K_SUBS: begin c.setflags = 1; c.aluop = 3'b011; c.regwrite = 1; end
            K_AND:  begin c.aluop = 3'b100; c.regwrite = 1; end
            K_EOR:  begin c.aluop = 3'b110; c.regwrite = 1; end
            K_LSR:  begin c.shiften = 1; c.aluop = 3'b000; c.regwrite = 1; end
            default: c = '0;
        endcase
        return c;
    endfunction

    function automatic logic cond_on(input logic [3:0] c);
        if (c == 4'h0) return TB_COND_EN[0];
        if (c == 4'h1) return TB_COND_EN[1];
        if (c == 4'hB) return TB_COND_EN[2];
        if (c == 4'hA) return TB_COND_EN[3];
        return 1'b0;
    endfunction

    function automatic logic cond_true(input logic [3:0] c, input logic [3:0] nzvc);
        logic n, z, v;
        n = nzvc[3]; z = nzvc[2]; v = nzvc[1];
        if (c == 4'h0) return z;
        if (c == 4'h1) return !z;
        if (c == 4'hB) return n != v;
        if (c == 4'hA) return n == v;
        return 1'b0;
    endfunction

    task automatic setv(input int i, input kind_e k, input logic [3:0] c, input logic v, input logic fl,
                        input logic rz, input logic [3:0] eid, input logic [9:0] ectl);
        tbl[i].k = k; tbl[i].cond = c; tbl[i].vld = v; tbl[i].fl = fl; tbl[i].rz = rz;
        tbl[i].exp_id = eid; tbl[i].exp_ctl = ectl;
    endtask

    task automatic model_clear();
        for (int f = 0; f < 2; f++) begin
            m_ex[f] = '0; m_mem[f] = '0; m_wb[f] = '0; m_exv[f] = 1'b0; m_flags[f] = 4'b0000;
        end
    endtask

    initial begin
        logic [9:0]  e_ex, e_mem, e_wb;
        logic [18:0] e_pack;
        kind_e       k;
        logic [3:0]  c, af, fs;
        logic        v, st, fl, rz, ok, bcl, legal, setter, haz, br, ld;

        // ---- vector table (alu flags held 0, so NZVC stays 0000) ----
        setv( 0, K_LDUR, 4'h0, 1, 0, 0, 4'b0000, 10'b1_0_0_010_0_1_1_1);
        setv( 1, K_BC,   4'h0, 1, 0, 0, 4'b0000, 10'b0);   // EQ, Z=0
        setv( 2, K_BC,   4'h1, 1, 0, 0, 4'b0010, 10'b0);   // NE
        setv( 3, K_BC,   4'hB, 1, 0, 0, 4'b0000, 10'b0);   // LT, N^V=0
        setv( 4, K_BC,   4'hA, 1, 0, 0, 4'b0001, 10'b0);   // GE disabled
        setv( 5, K_STUR, 4'h0, 1, 0, 0, 4'b1000, 10'b1_0_0_010_1_0_0_0);
        setv( 6, K_ADDI, 4'h0, 1, 0, 0, 4'b0000, 10'b1_0_0_010_0_0_1_0);
        setv( 7, K_ADDS, 4'h0, 1, 0, 0, 4'b0000, 10'b0_0_1_010_0_0_1_0);
        setv( 8, K_AND,  4'h0, 1, 0, 0, 4'b0000, 10'b0_0_0_100_0_0_1_0);
        setv( 9, K_SUBS, 4'h0, 1, 0, 0, 4'b0000, 10'b0_0_1_011_0_0_1_0);
        setv(10, K_EOR,  4'h0, 1, 0, 0, 4'b0000, 10'b0_0_0_110_0_0_1_0);
        setv(11, K_LSR,  4'h0, 1, 0, 0, 4'b0000, 10'b0_1_0_000_0_0_1_0);
        setv(12, K_B,    4'h0, 1, 0, 0, 4'b0110, 10'b0);
        setv(13, K_CBZ,  4'h0, 1, 0, 1, 4'b1010, 10'b0);
        setv(14, K_CBZ,  4'h0, 1, 0, 0, 4'b1000, 10'b0);
        setv(15, K_JUNK, 4'h0, 1, 0, 0, 4'b0001, 10'b0);
        setv(16, K_LDUR, 4'h0, 0, 0, 0, 4'b0000, 10'b0);   // bubble
        setv(17, K_CBZ,  4'h0, 1, 1, 1, 4'b0000, 10'b0);   // flushed
        setv(18, K_JUNK, 4'h0, 0, 0, 0, 4'b0000, 10'b0);
        setv(19, K_BC,   4'h5, 1, 0, 0, 4'b0001, 10'b0);   // unsupported cond
        setv(20, K_ADDS, 4'h0, 1, 1, 0, 4'b0000, 10'b0);   // flushed
        for (int i = 21; i < NV; i++) setv(i, K_LDUR, 4'h0, 0, 0, 0, 4'b0000, 10'b0);

        conds[0] = 4'h0; conds[1] = 4'h1; conds[2] = 4'hB; conds[3] = 4'hA; conds[4] = 4'h5;

        // ---- reset state ----
        drive(32'h0, 0, 0, 0, 0, 4'h0);
        reset = 1'b1;
        #1;
        chk("reset_state_fwd1", 32'(w1_pack), 32'h0);
        chk("reset_state_fwd0", 32'(w0_pack), 32'h0);
        cyc();
        cyc();
        reset = 1'b0;

        // ---- table ----
        for (int i = 0; i < NV; i++) begin
            drive(mk_instr(tbl[i].k, tbl[i].cond), tbl[i].vld, 1'b0, tbl[i].fl, tbl[i].rz, 4'h0);
            #3;
            e_ex = '0; e_mem = '0; e_wb = '0;
            if (i >= 1) e_ex  = tbl[i-1].exp_ctl;
            if (i >= 2) e_mem = tbl[i-2].exp_ctl;
            if (i >= 3) e_wb  = tbl[i-3].exp_ctl;
            e_pack = {tbl[i].exp_id[3], tbl[i].exp_id[2], tbl[i].exp_id[1], 1'b0, tbl[i].exp_id[0],
                      e_ex[9:4], e_mem[3:2], e_wb[1:0], 4'b0000};
            chk($sformatf("vec%0d_fwd1", i), 32'(w1_pack), 32'(e_pack));
            chk($sformatf("vec%0d_fwd0", i), 32'(w0_pack), 32'(e_pack));
            cyc();
        end

        // ---- reset mid-stream with LDUR in EX and flags set ----
        drive(mk_instr(K_ADDS, 4'h0), 1, 0, 0, 0, 4'hF);
        cyc();
        drive(mk_instr(K_LDUR, 4'h0), 1, 0, 0, 0, 4'hF);
        cyc();
        drive(32'h0, 0, 0, 0, 0, 4'h0);
        #1;
        chk("pre_rst_flags", 32'(o1_flags), 32'hF);
        chk("pre_rst_ex_alusrc", 32'(o1_alusrc), 32'h1);
        reset = 1'b1;
        #1;
        chk("mid_rst_fwd1", 32'(w1_pack), 32'h0);
        chk("mid_rst_fwd0", 32'(w0_pack), 32'h0);
        cyc();
        reset = 1'b0;
        drive(mk_instr(K_ADDI, 4'h0), 1, 0, 0, 0, 4'h0);
        cyc();
        drive(32'h0, 0, 0, 0, 0, 4'h0);
        #1;
        chk("post_rst_addi_aluop", 32'(o1_aluop), 32'h2);
        chk("post_rst_addi_alusrc", 32'(o1_alusrc), 32'h1);
        cyc();

        // ---- SUBS in EX, B.LT in ID: forward vs stall ----
        drive(mk_instr(K_SUBS, 4'h0), 1, 0, 0, 0, 4'h0);
        cyc();
        drive(mk_instr(K_BC, 4'hB), 1, 1, 0, 0, 4'b1000);
        #3;
        chk("blt_fwd1_br", 32'(o1_br), 32'h1);
        chk("blt_fwd1_haz", 32'(o1_fh), 32'h0);
        chk("blt_fwd0_haz", 32'(o0_fh), 32'h1);
        chk("blt_fwd0_br", 32'(o0_br), 32'h0);
        cyc();
        stall = 1'b0;
        {alu_n, alu_z, alu_v, alu_c} = 4'b0000;
        #3;
        chk("blt_fwd1_flags", 32'(o1_flags), 32'h8);
        chk("blt_fwd0_flags", 32'(o0_flags), 32'h8);
        chk("blt_fwd0_br_after", 32'(o0_br), 32'h1);
        chk("blt_fwd0_haz_after", 32'(o0_fh), 32'h0);
        chk("blt_fwd1_br_after", 32'(o1_br), 32'h1);
        cyc();

        // ---- flush and stall together on a hazarding B.cond ----
        drive(mk_instr(K_SUBS, 4'h0), 1, 0, 0, 0, 4'b1000);
        cyc();
        drive(mk_instr(K_BC, 4'hB), 1, 1, 1, 0, 4'b1000);
        #3;
        chk("fl_st_fwd0_haz", 32'(o0_fh), 32'h0);
        chk("fl_st_fwd0_br", 32'(o0_br), 32'h0);
        chk("fl_st_fwd1_br", 32'(o1_br), 32'h0);
        cyc();
        drive(32'h0, 0, 0, 0, 0, 4'h0);
        #1;
        chk("fl_st_ex_bubble", 32'({o1_alusrc, o1_shen, o1_setf, o1_aluop}), 32'h0);
        cyc();
        cyc();

        // ---- stalled STUR never reaches MEM ----
        drive(mk_instr(K_STUR, 4'h0), 1, 1, 0, 0, 4'h0);
        cyc();
        drive(32'h0, 0, 0, 0, 0, 4'h0);
        cyc();
        #1;
        chk("stall_stur_mw_fwd1", 32'(o1_mw), 32'h0);
        chk("stall_stur_mw_fwd0", 32'(o0_mw), 32'h0);

        // ---- randomized against the reference model ----
        reset = 1'b1;
        #1;
        cyc();
        reset = 1'b0;
        model_clear();
        for (int n = 0; n < 600; n++) begin
            if ($urandom_range(0, 49) == 0) begin
                drive(32'h0, 0, 0, 0, 0, 4'h0);
                reset = 1'b1;
                #1;
                chk("rand_rst_fwd1", 32'(w1_pack), 32'h0);
                chk("rand_rst_fwd0", 32'(w0_pack), 32'h0);
                cyc();
                reset = 1'b0;
                model_clear();
            end
            k  = kind_e'($urandom_range(0, 11));
            c  = conds[$urandom_range(0, 4)];
            v  = ($urandom_range(0, 9) < 8);
            st = ($urandom_range(0, 4) == 0);
            fl = ($urandom_range(0, 6) == 0);
            rz = 1'($urandom_range(0, 1));
            af = 4'($urandom_range(0, 15));
            drive(mk_instr(k, c), v, st, fl, rz, af);
            #3;
            ok    = v && !fl;
            bcl   = (k == K_BC) && cond_on(c);
            legal = (k != K_JUNK) && !((k == K_BC) && !cond_on(c));
            for (int f = 0; f < 2; f++) begin
                setter = m_exv[f] && m_ex[f].setflags;
                fs     = (f == 1 && setter) ? af : m_flags[f];
                haz    = (f == 0) && ok && bcl && setter;
                br     = ok && ((k == K_B) || ((k == K_CBZ) && rz) || (bcl && !haz && cond_true(c, fs)));
                e_pack = {ok && (k == K_STUR || k == K_CBZ), ok && (k == K_B), br, haz, ok && !legal,
                          m_ex[f][9:4], m_mem[f][3:2], m_wb[f][1:0], m_flags[f]};
                chk($sformatf("rand%0d_fwd%0d", n, f), 32'((f == 0) ? w0_pack : w1_pack), 32'(e_pack));
            end
            ld = v && !st && !fl;
            for (int f = 0; f < 2; f++) begin
                if (m_exv[f] && m_ex[f].setflags) m_flags[f] = af;
                m_wb[f]  = m_mem[f];
                m_mem[f] = m_ex[f];
                m_exv[f] = ld;
                m_ex[f]  = ld ? kind_ctl(k) : '0;
            end
            cyc();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
